// File: rtl/pic_row_window.sv
// Row-to-window converter: buffers the last K rows and streams every
// KxK sliding window of each complete band, one window per clock.
// Ports: clk/rst (sync, active-high); in_valid/in_row/in_ready row input;
// win_valid/win_data/win_row/win_col window output; frame_done pulse on
// the last window of an image; err_overrun sticky dropped-row flag.
module pic_row_window #(
  parameter int PIX_W = 8,
  parameter int COLS  = 28,
  parameter int ROWS  = 28,
  parameter int K     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [PIX_W*COLS-1:0]   in_row,
  output logic                    in_ready,
  output logic                    win_valid,
  output logic [K*K*PIX_W-1:0]    win_data,
  output logic [4:0]              win_row,
  output logic [4:0]              win_col,
  output logic                    frame_done,
  output logic                    err_overrun
);

  localparam int RW = PIX_W * COLS;
  localparam int WW = K * K * PIX_W;
  localparam logic [4:0] K_C    = 5'(K);
  localparam logic [4:0] ROWS_C = 5'(ROWS);
  localparam logic [4:0] LAST_C = 5'(COLS - K);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state_q, state_d;
  logic [4:0]      row_cnt_q, row_cnt_d;
  logic [4:0]      col_q, col_d;
  logic [4:0]      band_q, band_d;
  logic [RW-1:0]   lb_q [K];
  logic [RW-1:0]   lb_d [K];
  logic            in_ready_q, in_ready_d;
  logic            win_valid_q, win_valid_d;
  logic [WW-1:0]   win_data_q, win_data_d;
  logic [4:0]      win_row_q, win_row_d;
  logic [4:0]      win_col_q, win_col_d;
  logic            frame_done_q, frame_done_d;
  logic            err_q, err_d;
  logic [WW-1:0]   win_w;

  // Window at col_q: row r of the buffer, columns col_q..col_q+K-1.
  always_comb begin
    win_w = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_w[(K*K-1-(r*K+c))*PIX_W +: PIX_W] =
          lb_q[r][(COLS-1-(int'(col_q)+c))*PIX_W +: PIX_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    col_d        = col_q;
    band_d       = band_q;
    lb_d         = lb_q;
    win_valid_d  = 1'b0;
    win_data_d   = win_data_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < K-1; i++) begin
            lb_d[i] = lb_q[i+1];
          end
          lb_d[K-1] = in_row;
          row_cnt_d = row_cnt_q + 5'd1;
          if (row_cnt_d >= K_C) begin
            state_d = EMIT;
            col_d   = '0;
            band_d  = row_cnt_d - K_C;
          end
        end
      end
      EMIT: begin
        // A strobe here is dropped; only the sticky flag records it.
        if (in_valid) begin
          err_d = 1'b1;
        end
        win_valid_d = 1'b1;
        win_data_d  = win_w;
        win_row_d   = band_q;
        win_col_d   = col_q;
        col_d       = col_q + 5'd1;
        if (col_q == LAST_C) begin
          state_d = IDLE;
          col_d   = '0;
          if (row_cnt_q == ROWS_C) begin
            frame_done_d = 1'b1;
            row_cnt_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_cnt_q    <= '0;
      col_q        <= '0;
      band_q       <= '0;
      for (int i = 0; i < K; i++) begin
        lb_q[i] <= '0;
      end
      in_ready_q   <= 1'b1;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      col_q        <= col_d;
      band_q       <= band_d;
      lb_q         <= lb_d;
      in_ready_q   <= in_ready_d;
      win_valid_q  <= win_valid_d;
      win_data_q   <= win_data_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign win_valid   = win_valid_q;
  assign win_data    = win_data_q;
  assign win_row     = win_row_q;
  assign win_col     = win_col_q;
  assign frame_done  = frame_done_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_pic_row_window.sv
// Self-checking bench for pic_row_window: random and patterned rows,
// compared against a row-list model of the expected window stream.
module tb_pic_row_window;
  localparam int PIX_W = 8;
  localparam int COLS  = 28;
  localparam int ROWS  = 28;
  localparam int K     = 5;
  localparam int NW    = COLS - K + 1;
  localparam int RW    = PIX_W * COLS;
  localparam int WW    = K * K * PIX_W;

  typedef struct packed {
    logic [WW-1:0] d;
    logic [4:0]    r;
    logic [4:0]    c;
    logic          fd;
    int            t;
  } win_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [RW-1:0] in_row = '0;
  logic          in_ready, win_valid, frame_done, err_overrun;
  logic [WW-1:0] win_data;
  logic [4:0]    win_row, win_col;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  win_t gotq[$];
  win_t expq[$];

  logic [RW-1:0] mrows [ROWS];
  int   mn = 0;
  int   mbusy = 0;
  logic merr = 1'b0;

  pic_row_window dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_row(in_row),
    .in_ready(in_ready), .win_valid(win_valid), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .frame_done(frame_done),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Reference: list of accepted rows; each band yields NW windows on the
  // clocks following acceptance; the unit is busy for NW+1 clocks.
  always @(posedge clk) begin
    win_t w;
    cyc = cyc + 1;
    if (rst) begin
      mn = 0;
      mbusy = cyc + 1;
      merr = 1'b0;
      while (expq.size() > 0 && expq[$].t >= cyc) void'(expq.pop_back());
    end else if (in_valid) begin
      if (cyc >= mbusy) begin
        mrows[mn] = in_row;
        mn = mn + 1;
        mbusy = cyc + 1;
        if (mn >= K) begin
          for (int col = 0; col < NW; col++) begin
            w.d = '0;
            for (int r = 0; r < K; r++)
              for (int c = 0; c < K; c++)
                w.d[(K*K-1-(r*K+c))*PIX_W +: PIX_W] =
                  mrows[mn-K+r][(COLS-1-(col+c))*PIX_W +: PIX_W];
            w.r = 5'(mn - K);
            w.c = 5'(col);
            w.fd = (mn == ROWS) && (col == NW - 1);
            w.t = cyc + 1 + col;
            expq.push_back(w);
          end
          mbusy = cyc + NW + 1;
          if (mn == ROWS) mn = 0;
        end
      end else begin
        merr = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    win_t w;
    if (win_valid) begin
      w.d = win_data; w.r = win_row; w.c = win_col;
      w.fd = frame_done; w.t = cyc;
      gotq.push_back(w);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [RW-1:0] pat_row(input int r);
    logic [RW-1:0] row;
    for (int c = 0; c < COLS; c++)
      row[(COLS-1-c)*PIX_W +: PIX_W] = 8'((r * COLS + c) % 256);
    return row;
  endfunction

  task automatic rand_row(output logic [RW-1:0] row);
    for (int i = 0; i < RW / 32; i++) row[i*32 +: 32] = $urandom;
  endtask

  task automatic strobe(input logic [RW-1:0] row);
    @(negedge clk);
    in_valid = 1'b1;
    in_row = row;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    gotq.delete();
    expq.delete();
  endtask

  task automatic test_reset();
    logic [WW+13:0] want;
    want = {1'b1, {(WW+13){1'b0}}};
    do_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, win_valid, win_data, win_row, win_col, frame_done,
         err_overrun} !== want) begin
      errors++;
      $display("FAIL reset_outputs got rdy%0b v%0b r%0d c%0d fd%0b e%0b",
               in_ready, win_valid, win_row, win_col, frame_done, err_overrun);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (gotq.size() !== 0) begin
      errors++;
      $display("FAIL reset_idle got %0d windows want 0", gotq.size());
    end
  endtask

  task automatic test_first4();
    for (int i = 0; i < K - 1; i++) begin
      strobe(pat_row(i));
      repeat (24) begin
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || win_valid !== 1'b0) begin
          errors++;
          $display("FAIL first4_idle row %0d got rdy%0b v%0b want 1 0",
                   i, in_ready, win_valid);
        end
      end
    end
    #1;
    checks++;
    if (gotq.size() !== 0 || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL first4_none got %0d win err%0b want 0 0",
               gotq.size(), err_overrun);
    end
  endtask

  task automatic test_first_burst();
    logic [WW-1:0] w00;
    strobe(pat_row(K - 1));
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL burst_rdy k0 got %0b want 0", in_ready);
    end
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      checks++;
      if (win_valid !== (k <= 24) || in_ready !== (k >= 24)) begin
        errors++;
        $display("FAIL burst_timing k%0d got v%0b rdy%0b want %0b %0b",
                 k, win_valid, in_ready, k <= 24, k >= 24);
      end
    end
    #1;
    checks++;
    if (gotq.size() !== NW || expq.size() !== NW) begin
      errors++;
      $display("FAIL burst_count got %0d want %0d", gotq.size(), NW);
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i] || gotq[i].r !== 5'd0 || gotq[i].c !== 5'(i)) begin
        errors++;
        $display("FAIL burst_win[%0d] got r%0d c%0d t%0d want r0 c%0d t%0d",
                 i, gotq[i].r, gotq[i].c, gotq[i].t, i, expq[i].t);
      end
    end
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w00[(K*K-1-(r*K+c))*PIX_W +: PIX_W] = 8'(r * 28 + c);
    checks++;
    if (gotq.size() == 0 || gotq[0].d !== w00) begin
      errors++;
      $display("FAIL window00 got %h want %h",
               gotq.size() > 0 ? gotq[0].d : '0, w00);
    end
  endtask

  task automatic test_full_image();
    logic [RW-1:0] img [ROWS];
    win_t first[$];
    int nfd, bad;
    do_reset();
    for (int i = 0; i < ROWS; i++) rand_row(img[i]);
    for (int pass = 0; pass < 2; pass++) begin
      gotq.delete();
      expq.delete();
      for (int i = 0; i < ROWS; i++) begin
        strobe(img[i]);
        repeat (24) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (gotq.size() !== ROWS * 0 + (ROWS - K + 1) * NW || expq.size() !== 576) begin
        errors++;
        $display("FAIL image_count pass%0d got %0d want 576", pass, gotq.size());
      end
      for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
        checks++;
        if (gotq[i] !== expq[i]) begin
          errors++;
          $display("FAIL image_win[%0d] got r%0d c%0d fd%0b t%0d want r%0d c%0d fd%0b t%0d",
                   i, gotq[i].r, gotq[i].c, gotq[i].fd, gotq[i].t,
                   expq[i].r, expq[i].c, expq[i].fd, expq[i].t);
        end
      end
      nfd = 0;
      bad = 0;
      for (int i = 0; i < gotq.size(); i++) begin
        if (gotq[i].fd) nfd++;
        if (gotq[i].r !== 5'(i / NW) || gotq[i].c !== 5'(i % NW)) bad++;
      end
      checks++;
      if (nfd !== 1 || gotq.size() == 0 || gotq[$].fd !== 1'b1 ||
          gotq[$].r !== 5'd23 || gotq[$].c !== 5'd23) begin
        errors++;
        $display("FAIL frame_done pass%0d got %0d pulses want 1 at (23,23)",
                 pass, nfd);
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL row_steps pass%0d got %0d bad indices want 0", pass, bad);
      end
      if (pass == 0) begin
        first = gotq;
      end else begin
        bad = 0;
        for (int i = 0; i < gotq.size() && i < first.size(); i++)
          if (gotq[i].d !== first[i].d || gotq[i].r !== first[i].r ||
              gotq[i].c !== first[i].c || gotq[i].fd !== first[i].fd) bad++;
        checks++;
        if (bad !== 0 || gotq.size() !== first.size()) begin
          errors++;
          $display("FAIL repeat_image got %0d diffs size %0d want 0 size %0d",
                   bad, gotq.size(), first.size());
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [RW-1:0] rows [7];
    logic [RW-1:0] drop;
    int bad;
    do_reset();
    for (int i = 0; i < 7; i++) rand_row(rows[i]);
    drop = ~rows[5];
    for (int i = 0; i < K; i++) begin
      strobe(rows[i]);
      if (i < K - 1) repeat (24) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre got %0b want 0", err_overrun);
    end
    strobe(drop);
    checks++;
    if (err_overrun !== 1'b1 || merr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %0b want 1", err_overrun);
    end
    repeat (14) @(negedge clk);
    strobe(rows[5]);
    repeat (24) @(negedge clk);
    strobe(rows[6]);
    repeat (28) @(negedge clk);
    #1;
    checks++;
    if (gotq.size() !== 3 * NW || expq.size() !== 3 * NW) begin
      errors++;
      $display("FAIL overrun_count got %0d want %0d", gotq.size(), 3 * NW);
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        errors++;
        $display("FAIL overrun_win[%0d] got r%0d c%0d t%0d d%h want r%0d c%0d t%0d d%h",
                 i, gotq[i].r, gotq[i].c, gotq[i].t, gotq[i].d,
                 expq[i].r, expq[i].c, expq[i].t, expq[i].d);
      end
    end
    bad = 0;
    if (gotq.size() > NW) begin
      for (int c = 0; c < K; c++) begin
        if (gotq[NW].d[(K*K-1-(3*K+c))*PIX_W +: PIX_W] !==
            rows[4][(COLS-1-c)*PIX_W +: PIX_W]) bad++;
        if (gotq[NW].d[(K*K-1-(4*K+c))*PIX_W +: PIX_W] !==
            rows[5][(COLS-1-c)*PIX_W +: PIX_W]) bad++;
      end
    end else begin
      bad = 1;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL dropped_absent got %0d bad pixels want 0", bad);
    end
    checks++;
    if (err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky got %0b want 1", err_overrun);
    end
  endtask

  task automatic test_reset_midburst();
    logic [RW-1:0] row;
    logic [WW+13:0] want;
    want = {1'b1, {(WW+13){1'b0}}};
    do_reset();
    for (int i = 0; i < K; i++) begin
      rand_row(row);
      strobe(row);
      if (i < K - 1) repeat (24) @(negedge clk);
    end
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, win_valid, win_data, win_row, win_col, frame_done,
         err_overrun} !== want) begin
      errors++;
      $display("FAIL midreset_outputs got rdy%0b v%0b r%0d c%0d fd%0b e%0b",
               in_ready, win_valid, win_row, win_col, frame_done, err_overrun);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (gotq.size() !== 12 - 1 || expq.size() !== 11) begin
      errors++;
      $display("FAIL midreset_count got %0d want 11", gotq.size());
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        errors++;
        $display("FAIL midreset_win[%0d] got c%0d t%0d want c%0d t%0d",
                 i, gotq[i].c, gotq[i].t, expq[i].c, expq[i].t);
      end
    end
    gotq.delete();
    expq.delete();
    for (int i = 0; i < K; i++) begin
      rand_row(row);
      strobe(row);
      repeat (24) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (gotq.size() !== NW || gotq[0].r !== 5'd0 || gotq[0].c !== 5'd0) begin
      errors++;
      $display("FAIL midreset_after got %0d windows want %0d from row 0",
               gotq.size(), NW);
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        errors++;
        $display("FAIL midreset_after_win[%0d] got r%0d c%0d want r%0d c%0d",
                 i, gotq[i].r, gotq[i].c, expq[i].r, expq[i].c);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] row;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rand_row(row);
      strobe(row);
      repeat (23) @(negedge clk);
    end
    repeat (28) @(negedge clk);
    #1;
    checks++;
    if (err_overrun !== 1'b0 || gotq.size() !== 2 * NW || expq.size() !== 2 * NW) begin
      errors++;
      $display("FAIL b2b_count got %0d windows err%0b want %0d err0",
               gotq.size(), err_overrun, 2 * NW);
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        errors++;
        $display("FAIL b2b_win[%0d] got r%0d c%0d t%0d want r%0d c%0d t%0d",
                 i, gotq[i].r, gotq[i].c, gotq[i].t,
                 expq[i].r, expq[i].c, expq[i].t);
      end
    end
    checks++;
    if (gotq.size() < 2 * NW || gotq[NW].t - gotq[0].t !== 25) begin
      errors++;
      $display("FAIL b2b_spacing got %0d want 25",
               gotq.size() >= 2 * NW ? gotq[NW].t - gotq[0].t : -1);
    end
  endtask

  initial begin
    test_reset();
    test_first4();
    test_first_burst();
    test_full_image();
    test_overrun();
    test_reset_midburst();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
